// File: rtl/cmos_capture_crop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmos_capture_crop_pkg
// Purpose  : Shared widths and pixel type for the DVP capture/crop stage.
// Revision : 1.0 - initial release
// ============================================================================
package cmos_capture_crop_pkg;

  localparam int CNT_W_DEF = 11;
  localparam int SIZE_W    = 10;
  localparam int PIX_W     = 16;
  localparam int DVP_W     = 8;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage
`default_nettype wire

// File: rtl/dvp_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : dvp_byte_packer
// Purpose  : Pairs consecutive DVP bytes (high byte first) into RGB565 pixels.
// Revision : 1.0 - initial release
// ============================================================================
module dvp_byte_packer
  import cmos_capture_crop_pkg::*;
(
  input  logic             cam_pclk,
  input  logic             rst_n,
  input  logic             href_d0,
  input  logic [DVP_W-1:0] data_d0,
  output logic             pix_done,
  output rgb565_t          pixel
);

  logic             r_byte_flag;
  logic [DVP_W-1:0] r_high_byte;

  // Flag restarts at every line, so an odd trailing byte never pairs up.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_flag <= 1'b0;
      r_high_byte <= '0;
    end else begin
      r_byte_flag <= href_d0 ? ~r_byte_flag : 1'b0;
      if (href_d0 && !r_byte_flag)
        r_high_byte <= data_d0;
    end
  end

  assign pix_done = href_d0 & r_byte_flag;
  assign pixel    = rgb565_t'({r_high_byte, data_d0});

endmodule
`default_nettype wire

// File: rtl/cmos_capture_crop.sv
`default_nettype none
// ============================================================================
// Module   : cmos_capture_crop
// Purpose  : DVP capture with start-up frame discard and programmable crop.
// Revision : 1.0 - initial release
// ============================================================================
module cmos_capture_crop
  import cmos_capture_crop_pkg::*;
#(
  parameter int WAIT_FRAMES = 10,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [DVP_W-1:0]  cam_data,
  input  logic [CNT_W-1:0]  x_start,
  input  logic [CNT_W-1:0]  y_start,
  input  logic [SIZE_W-1:0] t_width,
  input  logic [SIZE_W-1:0] t_high,
  output logic              cmos_frame_vsync,
  output logic              cmos_frame_href,
  output logic              cmos_frame_valid,
  output logic [PIX_W-1:0]  cmos_frame_data,
  output logic              frame_ok
);

  localparam int WAIT_W = (WAIT_FRAMES < 1) ? 1 : $clog2(WAIT_FRAMES + 1);
  localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(WAIT_FRAMES);

  logic              r_vsync_d0, r_vsync_d1, r_href_d0, r_href_d1;
  logic [DVP_W-1:0]  r_data_d0;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_x_start, r_y_start, r_x, r_y;
  logic [SIZE_W-1:0] r_t_width, r_t_high;

  logic              w_vs_pos, w_hs_neg, w_pix_done, w_in_row, w_in_col;
  logic              w_win_open, w_valid;
  logic [CNT_W:0]    w_x_end, w_y_end;
  rgb565_t           w_pixel;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d0 <= 1'b0;
      r_vsync_d1 <= 1'b0;
      r_href_d0  <= 1'b0;
      r_href_d1  <= 1'b0;
      r_data_d0  <= '0;
    end else begin
      r_vsync_d0 <= cam_vsync;
      r_vsync_d1 <= r_vsync_d0;
      r_href_d0  <= cam_href;
      r_href_d1  <= r_href_d0;
      r_data_d0  <= cam_data;
    end
  end

  assign w_vs_pos = r_vsync_d0 & ~r_vsync_d1;
  assign w_hs_neg = ~r_href_d0 & r_href_d1;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      frame_ok   <= 1'b0;
    end else begin
      if (w_vs_pos && (r_wait_cnt < c_wait_max))
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      frame_ok <= frame_ok | (r_wait_cnt == c_wait_max);
    end
  end

  dvp_byte_packer u_packer (
    .cam_pclk (cam_pclk),
    .rst_n    (rst_n),
    .href_d0  (r_href_d0),
    .data_d0  (r_data_d0),
    .pix_done (w_pix_done),
    .pixel    (w_pixel)
  );

  // Window is frozen per frame; y saturates so oversize frames never wrap back in.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_start <= '0;
      r_y_start <= '0;
      r_t_width <= '0;
      r_t_high  <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      if (w_vs_pos) begin
        r_x_start <= x_start;
        r_y_start <= y_start;
        r_t_width <= t_width;
        r_t_high  <= t_high;
      end
      if (!r_href_d0)
        r_x <= '0;
      else if (w_pix_done)
        r_x <= r_x + CNT_W'(1);
      if (w_vs_pos)
        r_y <= '0;
      else if (w_hs_neg && (r_y != '1))
        r_y <= r_y + CNT_W'(1);
    end
  end

  assign w_x_end    = {1'b0, r_x_start} + {{(CNT_W + 1 - SIZE_W){1'b0}}, r_t_width};
  assign w_y_end    = {1'b0, r_y_start} + {{(CNT_W + 1 - SIZE_W){1'b0}}, r_t_high};
  assign w_in_row   = ({1'b0, r_y} >= {1'b0, r_y_start}) && ({1'b0, r_y} < w_y_end);
  assign w_in_col   = ({1'b0, r_x} >= {1'b0, r_x_start}) && ({1'b0, r_x} < w_x_end);
  assign w_win_open = (r_t_width != '0) && (r_t_high != '0);
  assign w_valid    = w_pix_done & w_in_row & w_in_col & frame_ok;

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_frame_vsync <= 1'b0;
      cmos_frame_href  <= 1'b0;
      cmos_frame_valid <= 1'b0;
      cmos_frame_data  <= '0;
    end else begin
      cmos_frame_vsync <= r_vsync_d0 & frame_ok;
      cmos_frame_href  <= r_href_d0 & w_in_row & w_win_open & frame_ok;
      cmos_frame_valid <= w_valid;
      if (w_valid)
        cmos_frame_data <= w_pixel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_crop.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmos_capture_crop
// Purpose  : Directed/random bench for cmos_capture_crop against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_capture_crop;

  localparam int WAIT = 2;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic [10:0] x_start = '0, y_start = '0;
  logic [9:0]  t_width = '0, t_high = '0;
  logic        cmos_frame_vsync, cmos_frame_href, cmos_frame_valid, frame_ok;
  logic [15:0] cmos_frame_data;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;

  cmos_capture_crop #(.WAIT_FRAMES(WAIT)) dut (
    .cam_pclk         (cam_pclk),
    .rst_n            (rst_n),
    .cam_vsync        (cam_vsync),
    .cam_href         (cam_href),
    .cam_data         (cam_data),
    .x_start          (x_start),
    .y_start          (y_start),
    .t_width          (t_width),
    .t_high           (t_high),
    .cmos_frame_vsync (cmos_frame_vsync),
    .cmos_frame_href  (cmos_frame_href),
    .cmos_frame_valid (cmos_frame_valid),
    .cmos_frame_data  (cmos_frame_data),
    .frame_ok         (frame_ok)
  );

  always #5 cam_pclk = ~cam_pclk;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  // Observed stream
  logic [15:0] got_pix[$];
  int          got_cyc[$];
  int          got_href = 0, got_vs = 0, bad_href = 0, ok_cyc = -1;
  logic        prev_href = 1'b0, prev_vs = 1'b0;

  always @(negedge cam_pclk) begin
    if (rst_n) begin
      if (cmos_frame_valid) begin
        got_pix.push_back(cmos_frame_data);
        got_cyc.push_back(cyc);
        if (!cmos_frame_href) bad_href++;
      end
      if (cmos_frame_href && !prev_href) got_href++;
      if (cmos_frame_vsync && !prev_vs) got_vs++;
      if (frame_ok && ok_cyc < 0) ok_cyc = cyc;
    end
    prev_href = cmos_frame_href;
    prev_vs   = cmos_frame_vsync;
  end

  // Reference model: frame/line/pixel bookkeeping
  logic [15:0] exp_pix[$];
  int          exp_cyc[$];
  int          exp_href = 0, exp_vs = 0;
  int          m_vs = 0, m_y = 0, m_xs = 0, m_ys = 0, m_w = 0, m_h = 0;
  logic [7:0]  line_buf[64];
  int          drv_cyc[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge cam_pclk);
      cam_href  = 1'b0;
      cam_vsync = 1'b0;
      cam_data  = 8'($urandom);
    end
  endtask

  task automatic send_vsync(output int drive_c);
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    drive_c   = cyc;
    @(negedge cam_pclk);
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    m_vs++;
    m_xs = int'(x_start);
    m_ys = int'(y_start);
    m_w  = int'(t_width);
    m_h  = int'(t_high);
    m_y  = 0;
    if (m_vs > WAIT) exp_vs++;
    idle(4);
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) line_buf[i] = 8'($urandom);
  endtask

  task automatic send_line(input int nbytes);
    bit ok, row;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge cam_pclk);
      cam_href   = 1'b1;
      cam_data   = line_buf[i];
      drv_cyc[i] = cyc;
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    ok  = (m_vs >= WAIT);
    row = ok && (m_y >= m_ys) && (m_y < m_ys + m_h);
    if (row && m_w > 0 && nbytes > 0) exp_href++;
    for (int p = 0; p < nbytes / 2; p++) begin
      if (row && p >= m_xs && p < m_xs + m_w) begin
        exp_pix.push_back({line_buf[2*p], line_buf[2*p+1]});
        exp_cyc.push_back(drv_cyc[2*p+1] + 2);
      end
    end
    if (m_y < 2047) m_y++;
    idle(4);
  endtask

  task automatic frame_lines(input int lines, input int nbytes);
    for (int l = 0; l < lines; l++) begin
      fill(nbytes);
      send_line(nbytes);
    end
  endtask

  task automatic clear_all();
    got_pix.delete(); got_cyc.delete(); exp_pix.delete(); exp_cyc.delete();
    got_href = 0; got_vs = 0; bad_href = 0; exp_href = 0; exp_vs = 0;
  endtask

  task automatic check_phase(input string tag);
    idle(6);
    check({tag, " n_pix"}, got_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      check({tag, " pix"}, got_pix[i], exp_pix[i]);
      check({tag, " lat"}, got_cyc[i], exp_cyc[i]);
    end
    check({tag, " href_lines"}, got_href, exp_href);
    check({tag, " vs_rises"}, got_vs, exp_vs);
    check({tag, " valid_out_of_href"}, bad_href, 0);
    clear_all();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " vsync"}, cmos_frame_vsync, 0);
    check({tag, " href"}, cmos_frame_href, 0);
    check({tag, " valid"}, cmos_frame_valid, 0);
    check({tag, " data"}, cmos_frame_data, 0);
    check({tag, " frame_ok"}, frame_ok, 0);
  endtask

  int c_vs;

  initial begin
    repeat (3) @(negedge cam_pclk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // A: frame discard, frame_ok timing
    x_start = 0; y_start = 0; t_width = 16; t_high = 16;
    frame_lines(8, 16);
    send_vsync(c_vs);
    check("A frame_ok_after_vs1", frame_ok, 0);
    frame_lines(8, 16);
    send_vsync(c_vs);
    frame_lines(8, 16);
    check("A frame_ok_rise", ok_cyc, c_vs + 3);
    check_phase("A");

    // B: known bytes, full window
    send_vsync(c_vs);
    line_buf[0] = 8'h12; line_buf[1] = 8'h34; line_buf[2] = 8'h56; line_buf[3] = 8'h78;
    send_line(4);
    idle(4);
    check("B n", got_pix.size(), 2);
    check("B pix0", got_pix[0], 16'h1234);
    check("B pix1", got_pix[1], 16'h5678);
    check_phase("B");

    // C: crop window on 8x8 pixel frame
    x_start = 2; t_width = 4; y_start = 1; t_high = 3;
    send_vsync(c_vs);
    frame_lines(8, 16);
    idle(4);
    check("C n", got_pix.size(), 12);
    check("C href_lines", got_href, 3);
    check_phase("C");

    // D: odd trailing byte
    x_start = 0; y_start = 0; t_width = 16; t_high = 16;
    send_vsync(c_vs);
    fill(7); send_line(7);
    fill(4); send_line(4);
    idle(4);
    check("D n", got_pix.size(), 5);
    check_phase("D");

    // E: width change mid-frame takes effect next frame
    t_width = 4;
    send_vsync(c_vs);
    frame_lines(1, 16);
    t_width = 6;
    frame_lines(2, 16);
    send_vsync(c_vs);
    frame_lines(2, 16);
    idle(4);
    check("E n", got_pix.size(), 24);
    check_phase("E");

    // F: empty windows
    t_width = 8; t_high = 0;
    send_vsync(c_vs);
    frame_lines(2, 16);
    t_width = 0; t_high = 8;
    send_vsync(c_vs);
    frame_lines(2, 16);
    idle(4);
    check("F n", got_pix.size(), 0);
    check("F href_lines", got_href, 0);
    check("F vs_rises", got_vs, 2);
    check_phase("F");

    // G: reset mid-line
    t_width = 16; t_high = 16;
    send_vsync(c_vs);
    fill(16);
    for (int i = 0; i < 9; i++) begin
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = line_buf[i];
    end
    @(posedge cam_pclk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge cam_pclk);
    cam_href = 1'b0;
    m_vs = 0; m_y = 0; m_xs = 0; m_ys = 0; m_w = 0; m_h = 0;
    ok_cyc = -1;
    clear_all();
    repeat (3) @(negedge cam_pclk);
    rst_n = 1'b1;
    send_vsync(c_vs);
    check("G frame_ok_after_vs1", frame_ok, 0);
    frame_lines(2, 16);
    send_vsync(c_vs);
    frame_lines(2, 16);
    check("G frame_ok_rise", ok_cyc, c_vs + 3);
    check_phase("G");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
